// File: rtl/key_expand_multi.sv
// key_expand_multi: AES key-schedule engine for 128/192/256-bit keys.
//
// Expands the cipher key into Nr+1 round keys, one 32-bit schedule word per
// clock, and writes each completed 128-bit round key to the round-key RAM.
// Rcon and the S-box are computed arithmetically (GF(2^8)), so no tables.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          one-cycle request; samples key and key_len
//   key_len        0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal
//   key            cipher key, word i at key[32i +: 32]
//   busy           high while expanding
//   round_key_addr RAM write address (round number)
//   round_key      RAM write data, word j at [32j +: 32]
//   w_e            one-cycle RAM write strobe
//   done           one-cycle pulse after the last write
//   err            one-cycle pulse on a start with key_len = 3
module key_expand_multi #(
    parameter int unsigned KEY_S   = 256,
    parameter int unsigned BLOCK_S = 128,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         key_len,
    input  logic [KEY_S-1:0]   key,
    output logic               busy,
    output logic [ADDR_W-1:0]  round_key_addr,
    output logic [BLOCK_S-1:0] round_key,
    output logic               w_e,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand, StFinish} state_e;

    state_e      state_q;
    logic [31:0] key_w_q [8];
    logic [31:0] hist_q  [8];   // hist_q[k] holds w[i-1-k]
    logic [31:0] pack0_q, pack1_q, pack2_q;
    logic [2:0]  nk_m1_q;       // Nk - 1
    logic [5:0]  last_q;        // index of the final schedule word
    logic [5:0]  i_q;           // schedule word index
    logic [2:0]  mod_q;         // i mod Nk
    logic [7:0]  rcon_q;

    logic [31:0] prev_w, back_w, temp_w, word;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, x);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, x);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, x);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, x);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, x);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // New byte0 = old byte1, ..., new byte3 = old byte0.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    always_comb begin
        prev_w = hist_q[0];
        back_w = hist_q[nk_m1_q];
        temp_w = prev_w;
        if (mod_q == 3'd0) begin
            temp_w = sub_word(rot_word(prev_w)) ^ {24'h0, rcon_q};
        end else if (nk_m1_q == 3'd7 && mod_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end
        word = (state_q == StLoad) ? key_w_q[i_q[2:0]] : (back_w ^ temp_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            busy           <= 1'b0;
            w_e            <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            round_key_addr <= '0;
            round_key      <= '0;
            pack0_q        <= '0;
            pack1_q        <= '0;
            pack2_q        <= '0;
            nk_m1_q        <= 3'd3;
            last_q         <= 6'd43;
            i_q            <= '0;
            mod_q          <= '0;
            rcon_q         <= 8'h01;
            for (int k = 0; k < 8; k++) begin
                key_w_q[k] <= '0;
                hist_q[k]  <= '0;
            end
        end else begin
            w_e  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            for (int k = 0; k < 8; k++) key_w_q[k] <= key[32*k +: 32];
                            unique case (key_len)
                                2'd0:    begin nk_m1_q <= 3'd3; last_q <= 6'd43; end
                                2'd1:    begin nk_m1_q <= 3'd5; last_q <= 6'd51; end
                                default: begin nk_m1_q <= 3'd7; last_q <= 6'd59; end
                            endcase
                            i_q     <= '0;
                            mod_q   <= '0;
                            rcon_q  <= 8'h01;
                            busy    <= 1'b1;
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad, StExpand: begin
                    hist_q[0] <= word;
                    for (int k = 1; k < 8; k++) hist_q[k] <= hist_q[k-1];
                    unique case (i_q[1:0])
                        2'd0: pack0_q <= word;
                        2'd1: pack1_q <= word;
                        2'd2: pack2_q <= word;
                        default: begin
                            round_key      <= {word, pack2_q, pack1_q, pack0_q};
                            round_key_addr <= ADDR_W'(i_q[5:2]);
                            w_e            <= 1'b1;
                        end
                    endcase
                    if (state_q == StExpand && mod_q == 3'd0) rcon_q <= xtime(rcon_q);
                    i_q   <= i_q + 6'd1;
                    mod_q <= (mod_q == nk_m1_q) ? 3'd0 : mod_q + 3'd1;
                    if (i_q == last_q) begin
                        state_q <= StFinish;
                    end else if (mod_q == nk_m1_q) begin
                        // Only changes state at the end of LOAD.
                        state_q <= StExpand;
                    end
                end
                StFinish: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expand_multi.sv
// Testbench for key_expand_multi: a schedule-level reference model (FIPS-197
// KeyExpansion plus the documented write/done timing) is compared against the
// DUT outputs on every falling clock edge while out of reset.
module tb_key_expand_multi;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key;
    logic         w_e;
    logic         done;
    logic         err;

    key_expand_multi #(
        .KEY_S   (256),
        .BLOCK_S (128),
        .ADDR_W  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .key_len        (key_len),
        .key            (key),
        .busy           (busy),
        .round_key_addr (round_key_addr),
        .round_key      (round_key),
        .w_e            (w_e),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]   sbox [256];
    logic [127:0] m_rk [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                       ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = b;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox[w[8*b +: 8]];
        return r;
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[7:0], t[31:8]});
                t[7:0] = t[7:0] ^ rc;
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            m_rk[r] = (r < total / 4) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : 128'h0;
    endtask

    // FIPS-197 byte-order hex (byte 0 leftmost) to the port packing (byte 0 at LSB).
    function automatic logic [255:0] fips_le(input logic [255:0] v, input int nbytes);
        logic [255:0] r;
        r = '0;
        for (int b = 0; b < nbytes; b++) r[8*b +: 8] = v[8*(nbytes-1-b) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
        return r;
    endfunction

    // Cycle-level expectations: t counts edges since the accepting start edge.
    logic         m_active = 1'b0;
    int           m_t = 0;
    int           m_n = 0;
    logic         e_busy = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [3:0]   e_addr = '0;
    logic [127:0] e_rk = '0;

    always @(posedge clk or negedge reset) begin : model
        int t;
        if (!reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            e_busy   <= 1'b0;
            e_we     <= 1'b0;
            e_done   <= 1'b0;
            e_err    <= 1'b0;
            e_addr   <= '0;
            e_rk     <= '0;
        end else begin
            e_we   <= 1'b0;
            e_done <= 1'b0;
            e_err  <= 1'b0;
            if (m_active) begin
                t = m_t + 1;
                m_t <= t;
                if (t % 4 == 0 && t <= m_n) begin
                    e_we   <= 1'b1;
                    e_addr <= 4'(t / 4 - 1);
                    e_rk   <= m_rk[t/4-1];
                end
                if (t == m_n + 1) begin
                    e_done   <= 1'b1;
                    e_busy   <= 1'b0;
                    m_active <= 1'b0;
                end
            end else if (start) begin
                if (key_len == 2'd3) begin
                    e_err <= 1'b1;
                end else begin
                    model_expand(key, 4 + 2 * int'(key_len));
                    m_n      <= 4 * (4 + 2 * int'(key_len) + 7);
                    m_t      <= 0;
                    m_active <= 1'b1;
                    e_busy   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("busy", 128'(busy), 128'(e_busy));
            chk("w_e", 128'(w_e), 128'(e_we));
            chk("done", 128'(done), 128'(e_done));
            chk("err", 128'(err), 128'(e_err));
            chk("round_key_addr", 128'(round_key_addr), 128'(e_addr));
            chk("round_key", round_key, e_rk);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [1:0] kl, input logic [255:0] k);
        start   = 1'b1;
        key_len = kl;
        key     = k;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key     = rand256();
        key_len = 2'($urandom_range(0, 3));
    endtask

    // Returns in the cycle done is high (or after the bound expires, cyc = 0).
    task automatic run(input logic [1:0] kl, input logic [255:0] k, input bit noise);
        int cyc;
        int exp_lat;
        cyc = 0;
        exp_lat = 4 * (4 + 2 * int'(kl) + 7) + 1;
        pulse_start(kl, k);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = c;
                start = 1'b0;
                break;
            end
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                key_len = 2'($urandom_range(0, 3));
                key     = rand256();
            end
        end
        start = 1'b0;
        chk("done_latency", 128'(cyc), 128'(exp_lat));
    endtask

    logic [255:0] tmp;
    int           nw;

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        key_len = 2'd0;
        key     = '0;

        // Pin the model with FIPS-197 values.
        build_sbox();
        chk("sbox_00", 128'(sbox[8'h00]), 128'h63);
        chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
        model_expand(fips_le(256'h2b7e151628aed2a6abf7158809cf4f3c, 16), 4);
        tmp = fips_le(256'ha0fafe1788542cb123a339392a6c7605, 16);
        chk("model128_r1", m_rk[1], tmp[127:0]);
        tmp = fips_le(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16);
        chk("model128_r10", m_rk[10], tmp[127:0]);
        model_expand(fips_le(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24), 6);
        tmp = fips_le(256'he98ba06f448c773c8ecc720401002202, 16);
        chk("model192_r12", m_rk[12], tmp[127:0]);
        model_expand(fips_le(
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32), 8);
        tmp = fips_le(256'hfe4890d1e6188d0b046df344706c631e, 16);
        chk("model256_r14", m_rk[14], tmp[127:0]);

        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_w_e", 128'(w_e), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        chk("rst_err", 128'(err), 128'h0);
        chk("rst_addr", 128'(round_key_addr), 128'h0);
        chk("rst_round_key", round_key, 128'h0);

        // FIPS keys; garbage in the unused upper words must be ignored.
        tmp = rand256();
        run(2'd0, {tmp[255:128], 128'h0} | fips_le(256'h2b7e151628aed2a6abf7158809cf4f3c, 16),
            1'b0);
        tmp = rand256();
        run(2'd1, {tmp[255:192], 192'h0}
            | fips_le(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24), 1'b0);
        run(2'd2, fips_le(
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32), 1'b1);

        // Illegal length, then a legal start straight after.
        pulse_start(2'd3, rand256());
        chk("illegal_err", 128'(err), 128'h1);
        chk("illegal_busy", 128'(busy), 128'h0);
        chk("illegal_w_e", 128'(w_e), 128'h0);
        run(2'($urandom_range(0, 2)), rand256(), 1'b0);

        // Back-to-back: the next start is raised during the done cycle.
        run(2'd2, rand256(), 1'b0);
        run(2'd0, rand256(), 1'b0);
        run(2'd1, rand256(), 1'b0);

        // Reset after the 5th write of an AES-256 expansion.
        pulse_start(2'd2, rand256());
        nw = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (w_e) nw++;
            if (nw == 5) break;
        end
        chk("writes_before_reset", 128'(nw), 128'd5);
        reset = 1'b0;
        #1;
        chk("async_busy", 128'(busy), 128'h0);
        chk("async_w_e", 128'(w_e), 128'h0);
        chk("async_done", 128'(done), 128'h0);
        chk("async_addr", 128'(round_key_addr), 128'h0);
        chk("async_round_key", round_key, 128'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run(2'd2, rand256(), 1'b0);

        for (int n = 0; n < 6; n++) run(2'($urandom_range(0, 2)), rand256(), 1'(n % 2));
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expand_multi.md
# key_expand_multi

Parametrised AES key-schedule engine that expands a 128-, 192- or 256-bit cipher key into Nr+1 128-bit round keys and writes them, one per address, into the round-key RAM read by the cipher datapath. It is the multi-key-length successor of the fixed-size round-key generator. The engine computes one 32-bit schedule word per clock, packs four words into a round key, and produces Rcon arithmetically rather than from a table. It sits between the AXI key-load logic (`start`/`key`) and the round-key RAM write port.

## Interface
- `KEY_S`, 256: width of `key` input; must be 256.
- `BLOCK_S`, 128: round-key width; must be 128.
- `ADDR_W`, 4: round-key RAM address width; must be ≥4 (addresses 0..14).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; samples `key` and `key_len`.
- `key_len`  in  2  0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = illegal.
- `key`  in  KEY_S  key; word i at `key[32i +: 32]`, byte 0 of word at bits [7:0]; FIPS-197 key byte k at `key[8k +: 8]`; unused upper words ignored.
- `busy`  out  1  high while expanding.
- `round_key_addr`  out  ADDR_W  RAM write address (round number).
- `round_key`  out  BLOCK_S  RAM write data; word j at `[32j +: 32]`.
- `w_e`  out  1  one-cycle RAM write strobe.
- `done`  out  1  one-cycle pulse after the last write.
- `err`  out  1  one-cycle pulse on start with `key_len`=3.

## Operation
- States: IDLE, LOAD, EXPAND, FINISH.
- IDLE: `start` with legal `key_len` latches key, Nk, Nr; word index i←0, Rcon←8'h01; → LOAD. `start` with `key_len`=3 pulses `err` and stays in IDLE.
- LOAD (i < Nk): emits w[i] = key word i, one per cycle; also shifts it into an 8-word history window. → EXPAND when i = Nk−1.
- EXPAND (Nk ≤ i < 4(Nr+1)): temp = w[i−1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {24'h0, Rcon}; Rcon ← xtime(Rcon) (shift left, XOR 8'h1B on carry-out).
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i−Nk] ^ temp.
  - i mod Nk is kept by a wrapping counter; no divider.
- RotWord in this byte order: new byte0 = old byte1, byte1 = byte2, byte2 = byte3, byte3 = byte0. SubWord applies the shared S-box function to each byte.
- Packer: each emitted word enters slot (i mod 4). When slot 3 fills, the 128-bit packer is registered to `round_key`, `round_key_addr` = i div 4, and `w_e` = 1.
- After word 4(Nr+1)−1 → FINISH: pulse `done` → IDLE.
- `start` while `busy` is ignored; no `err`.
- `key`/`key_len` changes after the start cycle have no effect.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; `busy`, `w_e`, `done`, `err` = 0; `round_key_addr` = 0; `round_key` = 0; Rcon = 8'h01.
- `start` sampled at edge E0. `busy` = 1 from E0 until the edge that raises `done`.
- Word i is computed in the cycle after edge E0+i.
- Write for round r is visible in the cycle after edge E0+4r+4; writes come exactly 4 cycles apart.
- `done` is high in the cycle after the last `w_e`, at edge E0+4(Nr+1)+1. `busy` falls on that same edge.
- Total latency from start edge to `done` is 45, 53 or 61 cycles for 128/192/256.
- A new `start` is accepted in the same cycle that `done` is high.
- Reset mid-expansion: outputs clear immediately; there is no `done`; RAM holds only the rounds already written.

## Test plan
- AES-128 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> 11 writes at addresses 0..10. Addr 1 = a0fafe17 88542cb1 23a33939 2a6c7605; addr 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; `done` 45 cycles after start.
- AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> 13 writes. Addr 12 = e98ba06f 448c773c 8ecc7204 01002202; `done` at cycle 53.
- AES-256 key 603deb10 … 0914dff4 -> 15 writes. Addr 14 = fe4890d1 e6188d0b 046df344 706c631e; verifies the i mod 8 = 4 SubWord path and Rcon through 8'h40.
- `key_len`=3 start -> `err` for one cycle, `busy` stays 0, no `w_e`. Then a legal start immediately after is accepted normally.
- `start` pulsed repeatedly during an AES-256 expansion -> write sequence and `done` timing unchanged. Back-to-back start in the `done` cycle -> second expansion begins with no gap.
- Drop `reset` low after the 5th write -> all outputs 0 asynchronously, no `done`. A restart after release produces a correct full schedule.
